mult_booth_seq: RTL and testbench
=================================

// Module: mult_booth_seq
// PURPOSE
//   Sequential signed 32x32 multiplier controller; radix-2 Booth, one iteration per cycle.
//   Owns no adder: drives operands into the shared 32-bit carry-select adder and consumes its
//   combinational sum in the same cycle. Serves the processor's MULT path; its latency is fixed.
// PARAMETERS
//   WIDTH    32  operand, result and adder width
//   CNT_W     6  iteration counter width; must hold WIDTH
// PORTS
//   clock         in   1      single clock; all state updates on the rising edge
//   reset_n       in   1      asynchronous, active-low reset
//   start         in   1      request; accepted only while IDLE
//   op_a          in   WIDTH  multiplicand M (signed); sampled on accept
//   op_b          in   WIDTH  multiplier Q (signed); sampled on accept
//   busy          out  1      high in RUN and DONE
//   result_valid  out  1      one-cycle pulse in DONE
//   result        out  WIDTH  low WIDTH bits of M*Q; held until the next accept
//   overflow      out  1      full product not representable in WIDTH signed bits; held with result
//   add_a         out  WIDTH  adder operand A = HI register
//   add_b         out  WIDTH  adder operand B: M, ~M or 0
//   add_cin       out  1      adder carry-in (1 only for subtract)
//   add_sum       in   WIDTH  adder sum; combinational from add_a/add_b/add_cin
// BEHAVIOUR
//   Reset (async, reset_n=0): state=IDLE; HI, LO, q_m1, M, count=0;
//     busy, result_valid, result, overflow=0; add_b=0, add_cin=0.
//   State: {HI[WIDTH], LO[WIDTH], q_m1[1]}; M register; count[CNT_W].
//   FSM IDLE -> RUN -> DONE -> IDLE.
//   - IDLE: if start: M<=op_a, HI<=0, LO<=op_b, q_m1<=0, count<=0, go RUN.
//   - RUN, each cycle, recode {LO[0],q_m1}:
//       01: add_b=M,  add_cin=0 (HI+M)
//       10: add_b=~M, add_cin=1 (HI-M)
//       00/11: add_b=0, add_cin=0 (pass)
//     v   = signed overflow of the adder op = (add_a[W-1]==add_b[W-1]) & (add_sum[W-1]!=add_a[W-1])
//     sgn = add_sum[W-1] ^ v (true sign; covers M = -2^(W-1))
//     {HI,LO,q_m1} <= {sgn, add_sum, LO} >> 1, i.e. HI<={sgn,add_sum[W-1:1]},
//       LO<={add_sum[0],LO[W-1:1]}, q_m1<=LO[0]
//     count<=count+1; after WIDTH iterations (count==WIDTH-1 this cycle) go DONE.
//   - DONE (1 cycle): result<=LO, overflow<=(HI != {WIDTH{LO[W-1]}}), result_valid=1, then IDLE.
//   - In IDLE/DONE: add_b=0, add_cin=0; add_a always equals HI.
//   Latency: start accepted at edge T; RUN occupies edges T+1..T+WIDTH;
//     result_valid high in the cycle after edge T+WIDTH+1 (33 cycles at W=32).
//   Boundaries:
//     start in RUN/DONE: ignored, never queued.
//     start held high: a new accept occurs on the first IDLE cycle after DONE.
//     Operands change after accept: no effect on the product.
//     reset_n low mid-RUN: immediate abort to the reset state; no result_valid.
//     result/overflow update only in DONE; stable otherwise.
// STRUCTURE
//   Shared package mult_pkg: state encodings (ST_IDLE, ST_RUN, ST_DONE);
//     Booth code constants (BOOTH_NOP, BOOTH_ADD, BOOTH_SUB); default WIDTH/CNT_W.
//   One sub-module: booth_recode({LO[0],q_m1}, M) -> add_b, add_cin (combinational).
//   FSM, counter and shift registers stay in this module. The adder is instantiated by the parent.
// TESTING (bench wires add_* to the team's 32-bit carry-select adder)
//   3 x 5: result=15, overflow=0; result_valid exactly 33 cycles after accept, one cycle wide.
//   -7 x 6: result=0xFFFFFFD6 (-42), overflow=0; busy high for 33 cycles.
//   0x7FFFFFFF x 2: result=0xFFFFFFFE, overflow=1.
//   0x80000000 x 0xFFFFFFFF: result=0x80000000, overflow=1 (HI=0).
//   0x80000000 x 0x80000000: result=0, overflow=1.
//   Pulse start at RUN cycle 10 with new operands: ignored; first product unchanged.
//   Drop reset_n at RUN cycle 20: all outputs 0 at once, no valid pulse.
//   Then 4 x 4 completes with result=16.
//   Random signed pairs (>=1000) checked against a 64-bit reference model.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier:
// FSM state encodings, Booth recode operations and default sizing.
package mult_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Indexed by {LO[0], q_m1}: 01 adds M, 10 subtracts M, 00/11 pass.
  typedef enum logic [1:0] {
    BOOTH_NOP = 2'b00,
    BOOTH_ADD = 2'b01,
    BOOTH_SUB = 2'b10
  } booth_op_t;

  function automatic booth_op_t booth_decode(input logic [1:0] bits);
    case (bits)
      2'b01:   return BOOTH_ADD;
      2'b10:   return BOOTH_SUB;
      default: return BOOTH_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_recode.sv
// Radix-2 Booth recoder: turns {LO[0], q_m1} and the multiplicand into the
// external adder's B operand and carry-in (subtract = add ~M with carry-in 1).
module booth_recode
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [1:0]       code,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin
);

  always_comb begin
    add_b   = '0;
    add_cin = 1'b0;
    case (booth_decode(code))
      BOOTH_ADD: add_b = m;
      BOOTH_SUB: begin
        add_b   = ~m;
        add_cin = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_booth_seq.sv
// Sequential signed WIDTHxWIDTH radix-2 Booth multiplier controller, one
// iteration per cycle, using a shared external adder for the HI accumulation.
module mult_booth_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum
);

  state_t           state;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             q_m1;
  logic [WIDTH-1:0] m_reg;
  logic [CNT_W-1:0] count;

  logic [WIDTH-1:0] rec_b;
  logic             rec_cin;
  logic             run;
  logic             add_ovf;
  logic             sgn;

  booth_recode #(.WIDTH(WIDTH)) u_recode (
    .code    ({lo[0], q_m1}),
    .m       (m_reg),
    .add_b   (rec_b),
    .add_cin (rec_cin)
  );

  assign run     = (state == ST_RUN);
  assign add_a   = hi;
  assign add_b   = run ? rec_b : '0;
  assign add_cin = run & rec_cin;

  // The true sign of HI +/- M needs the overflow correction, otherwise the
  // arithmetic shift goes wrong for M = -2^(WIDTH-1).
  assign add_ovf = (add_a[WIDTH-1] == add_b[WIDTH-1]) &
                   (add_sum[WIDTH-1] != add_a[WIDTH-1]);
  assign sgn     = add_sum[WIDTH-1] ^ add_ovf;

  // NOTE: all state is assigned with <= so every register samples the values
  // from before the edge; blocking assigns here would chain HI into LO.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      hi           <= '0;
      lo           <= '0;
      q_m1         <= 1'b0;
      m_reg        <= '0;
      count        <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      overflow     <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            m_reg <= op_a;
            hi    <= '0;
            lo    <= op_b;
            q_m1  <= 1'b0;
            count <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          hi    <= {sgn, add_sum[WIDTH-1:1]};
          lo    <= {add_sum[0], lo[WIDTH-1:1]};
          q_m1  <= lo[0];
          count <= count + CNT_W'(1);
          if (count == CNT_W'(WIDTH - 1)) state <= ST_DONE;
        end
        ST_DONE: begin
          result       <= lo;
          overflow     <= (hi != {WIDTH{lo[WIDTH-1]}});
          result_valid <= 1'b1;
          busy         <= 1'b0;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_booth_seq.sv
// Scoreboard bench for mult_booth_seq: stimulus pushes expected products from a
// 64-bit arithmetic model; a negedge monitor pops and compares on result_valid.
module tb_mult_booth_seq;

  localparam int W   = 32;
  localparam int LAT = 33;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         busy;
  logic         result_valid;
  logic [W-1:0] result;
  logic         overflow;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic         add_cin;
  logic [W-1:0] add_sum;

  // Stand-in for the shared carry-select adder: same function, plain arithmetic.
  assign add_sum = add_a + add_b + W'(add_cin);

  mult_booth_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .op_a         (op_a),
    .op_b         (op_b),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result),
    .overflow     (overflow),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_cin      (add_cin),
    .add_sum      (add_sum)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint p;
    p     = longint'($signed(a)) * longint'($signed(b));
    e.res = p[W-1:0];
    e.ovf = (p != longint'($signed(e.res)));
    e.acc = 0;
    return e;
  endfunction

  // Monitor: scoreboard compare, latency, busy width and result stability.
  int           busy_run = 0;
  logic [W:0]   prev_out = '0;
  always @(negedge clock) begin
    if (result_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.res);
        check("overflow", overflow, e.ovf);
        check("latency", cyc - e.acc, LAT);
      end
    end
    if (!reset_n || result_valid) prev_out = {overflow, result};
    else check("result_stable", {overflow, result}, prev_out);
    if (!reset_n) busy_run = 0;
    else if (busy) busy_run++;
    else if (busy_run > 0) begin
      check("busy_len", busy_run, LAT);
      busy_run = 0;
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clock);
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) check("idle_timeout", 1, 0);
  endtask

  // Returns at the negedge right after the accepting edge, start dropped.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    wait_idle();
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clock);
    #1;
    e     = model(a, b);
    e.acc = cyc;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0;
    op_a  = $urandom;
    op_b  = $urandom;
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 9))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'hFFFF_FFFF;
      3:       return W'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    exp_t e;
    int   n;

    #12;
    check("rst_busy", busy, 0);
    check("rst_valid", result_valid, 0);
    check("rst_result", result, 0);
    check("rst_overflow", overflow, 0);
    check("rst_add_a", add_a, 0);
    check("rst_add_b", add_b, 0);
    check("rst_add_cin", add_cin, 0);
    @(negedge clock);
    reset_n = 1'b1;

    issue(32'd3, 32'd5);
    issue(-32'sd7, 32'd6);
    issue(32'h7FFF_FFFF, 32'd2);
    issue(32'h8000_0000, 32'hFFFF_FFFF);
    issue(32'h8000_0000, 32'h8000_0000);

    // A start pulse during RUN must be ignored and never queued.
    issue(32'h0001_2345, 32'hFFFF_6789);
    repeat (9) @(negedge clock);
    op_a  = $urandom;
    op_b  = $urandom;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;

    // Start held high across a full operation: back-to-back accept at +34.
    wait_idle();
    op_a  = 32'hFFFF_FFF3;
    op_b  = 32'h0000_0123;
    start = 1'b1;
    @(posedge clock);
    #1;
    e     = model(32'hFFFF_FFF3, 32'h0000_0123);
    e.acc = cyc;
    sb.push_back(e);
    @(negedge clock);
    op_a  = 32'h0000_4000;
    op_b  = 32'hFFFF_8000;
    repeat (34) @(posedge clock);
    #1;
    e     = model(32'h0000_4000, 32'hFFFF_8000);
    e.acc = cyc;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0;

    // Reset mid-RUN aborts immediately with no valid pulse.
    issue(32'h0BAD_F00D, 32'h1234_5678);
    repeat (19) @(negedge clock);
    reset_n = 1'b0;
    #1;
    void'(sb.pop_back());
    check("abort_busy", busy, 0);
    check("abort_valid", result_valid, 0);
    check("abort_result", result, 0);
    check("abort_overflow", overflow, 0);
    check("abort_add_a", add_a, 0);
    check("abort_add_b", add_b, 0);
    check("abort_add_cin", add_cin, 0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);

    issue(32'd4, 32'd4);

    for (int i = 0; i < 1000; i++) issue(pick_operand(), pick_operand());

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("drain", sb.size(), 0);
    repeat (3) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
